core_pc_ctrl: RTL and testbench

CORE_PC_CTRL -- requirements
Module: core_pc_ctrl

---
 rtl/core_pc_ctrl_pkg.sv | 22 ++
 rtl/core_pc_ctrl_if.sv | 28 ++
 rtl/core_pc_ctrl_redirect_buf.sv | 59 +++++
 rtl/core_pc_ctrl.sv | 125 ++++++++++++
 tb/tb_core_pc_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/core_pc_ctrl_pkg.sv
// Shared PC-controller definitions: PC width, reset vector, FSM encoding and
// the target alignment helper.
package core_pc_ctrl_pkg;

   localparam int unsigned CPU_PC_SIZE = 64;

   typedef logic [CPU_PC_SIZE-1:0] pc_t;

   localparam pc_t RST_PC_DEFAULT = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      S_BOOT = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10,
      S_HALT = 2'b11
   } pc_state_e;

   function automatic pc_t align_pc(input pc_t pc);
      return {pc[CPU_PC_SIZE-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/core_pc_ctrl_if.sv
// Instruction-fetch request/response channel between the PC controller
// (master) and the fetch unit (slave).
interface core_pc_ctrl_if;
   import core_pc_ctrl_pkg::*;

   logic ifu_req_valid_o;
   logic ifu_req_ready_i;
   pc_t  ifu_req_addr_o;
   logic ifu_rsp_valid_i;
   logic ifu_rsp_drop_o;

   modport master (
      output ifu_req_valid_o,
      output ifu_req_addr_o,
      output ifu_rsp_drop_o,
      input  ifu_req_ready_i,
      input  ifu_rsp_valid_i
   );

   modport slave (
      input  ifu_req_valid_o,
      input  ifu_req_addr_o,
      input  ifu_rsp_drop_o,
      output ifu_req_ready_i,
      output ifu_rsp_valid_i
   );

endinterface

// File: rtl/core_pc_ctrl_redirect_buf.sv
// Holds one trap/redirect that arrives while a fetch is outstanding; a trap
// is sticky against later redirects, a newer redirect replaces an older one.
module core_pc_redirect_buf
   import core_pc_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic capture_i,
   input  logic clear_i,
   input  logic trap_valid_i,
   input  pc_t  trap_pc_i,
   input  logic redir_valid_i,
   input  pc_t  redir_pc_i,
   output logic pend_valid_o,
   output logic pend_is_trap_o,
   output pc_t  pend_pc_o
);

   logic pend_valid_d, pend_valid_q;
   logic pend_is_trap_d, pend_is_trap_q;
   pc_t  pend_pc_d, pend_pc_q;

   always_comb begin
      pend_valid_d   = pend_valid_q;
      pend_is_trap_d = pend_is_trap_q;
      pend_pc_d      = pend_pc_q;
      if (clear_i) begin
         pend_valid_d   = 1'b0;
         pend_is_trap_d = 1'b0;
      end else if (capture_i) begin
         if (trap_valid_i) begin
            pend_valid_d   = 1'b1;
            pend_is_trap_d = 1'b1;
            pend_pc_d      = trap_pc_i;
         end else if (redir_valid_i && !(pend_valid_q && pend_is_trap_q)) begin
            pend_valid_d   = 1'b1;
            pend_is_trap_d = 1'b0;
            pend_pc_d      = redir_pc_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_valid_q   <= 1'b0;
         pend_is_trap_q <= 1'b0;
         pend_pc_q      <= '0;
      end else begin
         pend_valid_q   <= pend_valid_d;
         pend_is_trap_q <= pend_is_trap_d;
         pend_pc_q      <= pend_pc_d;
      end
   end

   assign pend_valid_o   = pend_valid_q;
   assign pend_is_trap_o = pend_is_trap_q;
   assign pend_pc_o      = pend_pc_q;

endmodule

// File: rtl/core_pc_ctrl.sv
// PC sequencing FSM: boots to RST_PC, issues one fetch at a time and picks
// the next PC from sequential, redirect and trap sources.
module core_pc_ctrl
   import core_pc_ctrl_pkg::*;
#(
   parameter pc_t RST_PC = RST_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  pc_t               pc_cur_i,
   output pc_t               pc_nxt_o,
   output logic              pc_wen_o,
   core_pc_ctrl_if.master    ifu,
   input  logic              stall_i,
   input  logic              redirect_valid_i,
   input  pc_t               redirect_pc_i,
   input  logic              trap_valid_i,
   input  pc_t               trap_pc_i,
   input  logic              halt_i,
   output logic              halted_o
);

   pc_state_e state_d, state_q;
   logic      halt_pend_d, halt_pend_q;
   logic      buf_capture, buf_clear;
   logic      pend_valid, pend_is_trap;
   pc_t       pend_pc;
   pc_t       flush_target;
   logic      flush;

   core_pc_redirect_buf u_redirect_buf (
      .clk            (clk),
      .rst_n          (rst_n),
      .capture_i      (buf_capture),
      .clear_i        (buf_clear),
      .trap_valid_i   (trap_valid_i),
      .trap_pc_i      (trap_pc_i),
      .redir_valid_i  (redirect_valid_i),
      .redir_pc_i     (redirect_pc_i),
      .pend_valid_o   (pend_valid),
      .pend_is_trap_o (pend_is_trap),
      .pend_pc_o      (pend_pc)
   );

   always_comb begin
      flush = trap_valid_i || redirect_valid_i || pend_valid;
      if (trap_valid_i)                    flush_target = trap_pc_i;
      else if (pend_valid && pend_is_trap) flush_target = pend_pc;
      else if (redirect_valid_i)           flush_target = redirect_pc_i;
      else                                 flush_target = pend_pc;
   end

   always_comb begin
      state_d             = state_q;
      halt_pend_d         = halt_pend_q;
      pc_wen_o            = 1'b0;
      pc_nxt_o            = pc_cur_i;
      ifu.ifu_req_valid_o = 1'b0;
      ifu.ifu_rsp_drop_o  = 1'b0;
      buf_capture         = 1'b0;
      buf_clear           = 1'b0;
      case (state_q)
         S_BOOT: begin
            pc_wen_o = 1'b1;
            pc_nxt_o = align_pc(RST_PC);
            state_d  = S_REQ;
         end
         S_REQ: begin
            if (trap_valid_i) begin
               pc_wen_o = 1'b1;
               pc_nxt_o = align_pc(trap_pc_i);
            end else if (redirect_valid_i) begin
               pc_wen_o = 1'b1;
               pc_nxt_o = align_pc(redirect_pc_i);
            end else if (halt_i) begin
               state_d = S_HALT;
            end else begin
               ifu.ifu_req_valid_o = !stall_i;
               if (!stall_i && ifu.ifu_req_ready_i) state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ifu.ifu_rsp_valid_i) begin
               pc_wen_o    = 1'b1;
               buf_clear   = 1'b1;
               halt_pend_d = 1'b0;
               state_d     = S_REQ;
               // A flushed response also discards any halt seen behind it.
               if (flush) begin
                  ifu.ifu_rsp_drop_o = 1'b1;
                  pc_nxt_o           = align_pc(flush_target);
               end else begin
                  pc_nxt_o = pc_cur_i + 64'd4;
                  if (halt_pend_q || halt_i) state_d = S_HALT;
               end
            end else begin
               buf_capture = 1'b1;
               if (halt_i) halt_pend_d = 1'b1;
            end
         end
         S_HALT: ;
         default: state_d = S_BOOT;
      endcase
      if (!rst_n) begin
         pc_wen_o            = 1'b0;
         ifu.ifu_req_valid_o = 1'b0;
         ifu.ifu_rsp_drop_o  = 1'b0;
         buf_capture         = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_BOOT;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   assign ifu.ifu_req_addr_o = pc_cur_i;
   assign halted_o           = rst_n && (state_q == S_HALT);

endmodule

// File: tb/tb_core_pc_ctrl.sv
// Directed and randomized checks of core_pc_ctrl against a cycle-level
// behavioural model of the fetch/PC rules.
module tb_core_pc_ctrl;

   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] pc_cur;
   logic [63:0] pc_nxt;
   logic        pc_wen;
   logic        stall, redir_v, trap_v, halt, halted;
   logic [63:0] redir_pc, trap_pc;

   core_pc_ctrl_if ifu ();

   core_pc_ctrl #(.RST_PC(RST_PC)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pc_cur_i         (pc_cur),
      .pc_nxt_o         (pc_nxt),
      .pc_wen_o         (pc_wen),
      .ifu              (ifu.master),
      .stall_i          (stall),
      .redirect_valid_i (redir_v),
      .redirect_pc_i    (redir_pc),
      .trap_valid_i     (trap_v),
      .trap_pc_i        (trap_pc),
      .halt_i           (halt),
      .halted_o         (halted)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Model state: booting / fetch outstanding / halted, plus pending flush info.
   bit          m_boot = 1'b1;
   bit          m_busy = 1'b0;
   bit          m_halted = 1'b0;
   bit          m_halt_pend = 1'b0;
   int          m_pend_kind = 0;      // 0 none, 1 redirect, 2 trap
   logic [63:0] m_pend_pc = '0;

   function automatic logic [63:0] word_align(input logic [63:0] a);
      return a - (a % 64'd4);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst_n = 1'b1; stall = 1'b0; redir_v = 1'b0; trap_v = 1'b0; halt = 1'b0;
      ifu.ifu_req_ready_i = 1'b1; ifu.ifu_rsp_valid_i = 1'b0;
   endtask

   // One clock: check outputs mid-cycle against the model, advance the model,
   // then move the PC register to what the model says was written.
   task automatic cycle();
      logic        e_wen, e_req, e_drop, e_halted;
      logic [63:0] e_nxt;
      logic [63:0] tgt;
      bit          have_tgt;
      @(negedge clk);
      e_wen = 0; e_req = 0; e_drop = 0; e_nxt = '0;
      e_halted = rst_n && m_halted;
      if (!rst_n) begin
         m_boot = 1; m_busy = 0; m_halted = 0; m_halt_pend = 0; m_pend_kind = 0;
      end else if (m_halted) begin
      end else if (m_boot) begin
         e_wen = 1; e_nxt = RST_PC; m_boot = 0;
      end else if (!m_busy) begin
         if (trap_v) begin e_wen = 1; e_nxt = word_align(trap_pc); end
         else if (redir_v) begin e_wen = 1; e_nxt = word_align(redir_pc); end
         else if (halt) m_halted = 1;
         else begin
            e_req = !stall;
            if (e_req && ifu.ifu_req_ready_i) m_busy = 1;
         end
      end else if (ifu.ifu_rsp_valid_i) begin
         have_tgt = 1;
         if (trap_v) tgt = trap_pc;
         else if (m_pend_kind == 2) tgt = m_pend_pc;
         else if (redir_v) tgt = redir_pc;
         else if (m_pend_kind == 1) tgt = m_pend_pc;
         else begin have_tgt = 0; tgt = '0; end
         e_wen = 1; m_busy = 0;
         if (have_tgt) begin
            e_drop = 1; e_nxt = word_align(tgt);
         end else begin
            e_nxt = pc_cur + 64'd4;
            if (m_halt_pend || halt) m_halted = 1;
         end
         m_pend_kind = 0; m_halt_pend = 0;
      end else begin
         if (trap_v) begin m_pend_kind = 2; m_pend_pc = trap_pc; end
         else if (redir_v && m_pend_kind != 2) begin m_pend_kind = 1; m_pend_pc = redir_pc; end
         if (halt) m_halt_pend = 1;
      end
      chk("pc_wen", pc_wen, e_wen);
      chk("req_valid", ifu.ifu_req_valid_o, e_req);
      chk("rsp_drop", ifu.ifu_rsp_drop_o, e_drop);
      chk("halted", halted, e_halted);
      chk("req_addr", ifu.ifu_req_addr_o, pc_cur);
      if (e_wen) chk("pc_nxt", pc_nxt, e_nxt);
      @(posedge clk);
      #1;
      if (e_wen) pc_cur = e_nxt;
   endtask

   initial begin
      idle();
      pc_cur = '0; redir_pc = '0; trap_pc = '0;
      rst_n = 1'b0;
      cycle(); cycle();

      // Boot and two sequential fetches.
      rst_n = 1'b1;
      cycle();                                   chk("boot_pc", pc_cur, 64'h8000_0000);
      cycle();
      ifu.ifu_rsp_valid_i = 1; cycle(); ifu.ifu_rsp_valid_i = 0;
      chk("seq_pc1", pc_cur, 64'h8000_0004);
      cycle();
      ifu.ifu_rsp_valid_i = 1; cycle(); ifu.ifu_rsp_valid_i = 0;
      chk("seq_pc2", pc_cur, 64'h8000_0008);

      // Redirect while idle, unaligned target.
      redir_v = 1; redir_pc = 64'h8000_0103; cycle(); redir_v = 0;
      chk("redir_req", pc_cur, 64'h8000_0100);

      // Redirect while waiting, response two cycles later.
      cycle();
      redir_v = 1; redir_pc = 64'h8000_0200; cycle(); redir_v = 0;
      cycle();
      ifu.ifu_rsp_valid_i = 1; cycle(); ifu.ifu_rsp_valid_i = 0;
      chk("redir_wait", pc_cur, 64'h8000_0200);

      // Pending redirect then trap; then redirect alongside the response.
      cycle();
      redir_v = 1; redir_pc = 64'h200; cycle(); redir_v = 0;
      trap_v = 1; trap_pc = 64'h8000_1000; cycle(); trap_v = 0;
      ifu.ifu_rsp_valid_i = 1; cycle(); ifu.ifu_rsp_valid_i = 0;
      chk("trap_wins", pc_cur, 64'h8000_1000);
      cycle();
      redir_v = 1; redir_pc = 64'h200; ifu.ifu_rsp_valid_i = 1; cycle();
      redir_v = 0; ifu.ifu_rsp_valid_i = 0;
      chk("redir_same", pc_cur, 64'h200);

      // PC wrap and halt behind an outstanding fetch.
      pc_cur = 64'hFFFF_FFFF_FFFF_FFFC;
      cycle();
      ifu.ifu_rsp_valid_i = 1; cycle(); ifu.ifu_rsp_valid_i = 0;
      chk("pc_wrap", pc_cur, 64'h0);
      cycle();
      halt = 1; cycle(); halt = 0;
      ifu.ifu_rsp_valid_i = 1; cycle(); ifu.ifu_rsp_valid_i = 0;
      chk("halt_pc", pc_cur, 64'h4);
      repeat (3) cycle();
      chk("halted_stays", halted, 1'b1);

      // Reset during an outstanding fetch; late response lands in boot.
      rst_n = 0; cycle(); rst_n = 1;
      cycle(); cycle();
      rst_n = 0; cycle(); rst_n = 1;
      ifu.ifu_rsp_valid_i = 1; cycle(); ifu.ifu_rsp_valid_i = 0;
      chk("late_rsp_pc", pc_cur, RST_PC);
      cycle();
      ifu.ifu_rsp_valid_i = 1; cycle(); ifu.ifu_rsp_valid_i = 0;
      chk("reissue_pc", pc_cur, RST_PC + 64'd4);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rst_n    = !($urandom_range(0, 79) == 0) && !(m_halted && $urandom_range(0, 7) == 0);
         stall    = ($urandom_range(0, 3) == 0);
         trap_v   = ($urandom_range(0, 15) == 0);
         redir_v  = ($urandom_range(0, 5) == 0);
         halt     = ($urandom_range(0, 59) == 0);
         trap_pc  = {$urandom, $urandom};
         redir_pc = {$urandom, $urandom};
         ifu.ifu_req_ready_i = $urandom_range(0, 1) == 1;
         ifu.ifu_rsp_valid_i = m_busy && ($urandom_range(0, 2) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
